// File: rtl/cond_exec_unit.sv
// Execute-stage conditional-execution unit: NZCV register, ARM condition decode,
// gated E->M control register and a saturating count of condition-failed instructions.
module cond_exec_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_e,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic [3:0]       cond_e,
   input  logic [3:0]       alu_flags_e,
   input  logic [1:0]       flag_write_e,
   input  logic             reg_write_e,
   input  logic             mem_write_e,
   input  logic             pcs_e,
   input  logic             clr_count,
   output logic [3:0]       flags_q,
   output logic             carry_q,
   output logic             cond_ex_e,
   output logic             pc_src_e,
   output logic             reg_write_m,
   output logic             mem_write_m,
   output logic             pcs_m,
   output logic             valid_m,
   output logic [CNT_W-1:0] squash_count
);

   logic [3:0]       flags_d;
   logic             reg_write_m_q, reg_write_m_d;
   logic             mem_write_m_q, mem_write_m_d;
   logic             pcs_m_q, pcs_m_d;
   logic             valid_m_q, valid_m_d;
   logic [CNT_W-1:0] squash_q, squash_d;
   logic             flag_n, flag_z, flag_c, flag_v;
   logic             live, commit;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Decode uses the registered flags only; same-cycle ALU flags are never forwarded.
   always_comb begin
      cond_ex_e = 1'b1;
      case (cond_e)
         4'h0:    cond_ex_e = flag_z;
         4'h1:    cond_ex_e = !flag_z;
         4'h2:    cond_ex_e = flag_c;
         4'h3:    cond_ex_e = !flag_c;
         4'h4:    cond_ex_e = flag_n;
         4'h5:    cond_ex_e = !flag_n;
         4'h6:    cond_ex_e = flag_v;
         4'h7:    cond_ex_e = !flag_v;
         4'h8:    cond_ex_e = flag_c & !flag_z;
         4'h9:    cond_ex_e = !flag_c | flag_z;
         4'hA:    cond_ex_e = (flag_n == flag_v);
         4'hB:    cond_ex_e = (flag_n != flag_v);
         4'hC:    cond_ex_e = !flag_z & (flag_n == flag_v);
         4'hD:    cond_ex_e = flag_z | (flag_n != flag_v);
         default: cond_ex_e = 1'b1;
      endcase
   end

   assign live     = valid_e & !flush_e & !stall_e;
   assign commit   = live & cond_ex_e;
   assign pc_src_e = commit & pcs_e;
   assign carry_q  = flags_q[1];

   always_comb begin
      flags_d       = flags_q;
      reg_write_m_d = reg_write_m_q;
      mem_write_m_d = mem_write_m_q;
      pcs_m_d       = pcs_m_q;
      valid_m_d     = valid_m_q;
      squash_d      = squash_q;

      if (commit && flag_write_e[1]) flags_d[3:2] = alu_flags_e[3:2];
      if (commit && flag_write_e[0]) flags_d[1:0] = alu_flags_e[1:0];

      // Flush inserts a bubble even when the stage is also stalled.
      if (flush_e) begin
         reg_write_m_d = 1'b0;
         mem_write_m_d = 1'b0;
         pcs_m_d       = 1'b0;
         valid_m_d     = 1'b0;
      end else if (!stall_e) begin
         reg_write_m_d = commit & reg_write_e;
         mem_write_m_d = commit & mem_write_e;
         pcs_m_d       = commit & pcs_e;
         valid_m_d     = commit;
      end

      if (clr_count) begin
         squash_d = '0;
      end else if (live && !cond_ex_e && !(&squash_q)) begin
         squash_d = squash_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q       <= RESET_FLAGS;
         reg_write_m_q <= 1'b0;
         mem_write_m_q <= 1'b0;
         pcs_m_q       <= 1'b0;
         valid_m_q     <= 1'b0;
         squash_q      <= '0;
      end else begin
         flags_q       <= flags_d;
         reg_write_m_q <= reg_write_m_d;
         mem_write_m_q <= mem_write_m_d;
         pcs_m_q       <= pcs_m_d;
         valid_m_q     <= valid_m_d;
         squash_q      <= squash_d;
      end
   end

   assign reg_write_m  = reg_write_m_q;
   assign mem_write_m  = mem_write_m_q;
   assign pcs_m        = pcs_m_q;
   assign valid_m      = valid_m_q;
   assign squash_count = squash_q;

endmodule
